// File: rtl/rst_strap_seq_if.sv
// Strap-sequencer bus: soft-reboot request in, staged reset/enable outputs
// and status out.
// soft_reboot_req is a level from another domain; only its rising edge seen
// while running counts. No valid/ready pairs on this bus: every output is a
// registered level that is valid in every cycle.
interface rst_strap_seq_if;
  logic       soft_reboot_req;
  logic       p_reset_n;
  logic       clk_enb;
  logic       s_reset_n;
  logic [2:0] seq_state;
  logic [7:0] boot_cnt;

  modport master (
    input  soft_reboot_req,
    output p_reset_n, clk_enb, s_reset_n, seq_state, boot_cnt
  );

  modport slave (
    output soft_reboot_req,
    input  p_reset_n, clk_enb, s_reset_n, seq_state, boot_cnt
  );
endinterface

// File: rtl/rst_strap_seq.sv
// Reset-removal sequencer: p_reset_n, then clk_enb, then s_reset_n after
// external reset, plus a soft-reboot flow that leaves p_reset_n high.
module rst_strap_seq #(
  parameter int unsigned PRST_DLY  = 4,
  parameter int unsigned CLKEN_DLY = 2,
  parameter int unsigned SRST_DLY  = 3
) (
  input  logic            clk,
  input  logic            e_reset_n,
  rst_strap_seq_if.master bus
);

  typedef enum logic [2:0] {
    PRST  = 3'd0,
    CLKEN = 3'd1,
    SRST  = 3'd2,
    RUN   = 3'd3,
    HOLD  = 3'd4
  } state_t;

  localparam logic [15:0] PRST_END  = 16'(PRST_DLY - 1);
  localparam logic [15:0] CLKEN_END = 16'(CLKEN_DLY - 1);
  localparam logic [15:0] SRST_END  = 16'(SRST_DLY - 1);

  state_t      state;
  logic [15:0] cnt;
  logic        sync1, sync2, sync3;
  logic        p_q, ce_q, s_q;
  logic [7:0]  boot_q;
  logic        rise;

  // sync3 follows sync2 in every state, so a request that is still high
  // when RUN is re-entered does not retrigger.
  assign rise = sync2 & ~sync3;

  always_ff @(posedge clk or negedge e_reset_n) begin
    if (!e_reset_n) begin
      sync1 <= 1'b0;
      sync2 <= 1'b0;
      sync3 <= 1'b0;
    end else begin
      sync1 <= bus.soft_reboot_req;
      sync2 <= sync1;
      sync3 <= sync2;
    end
  end

  always_ff @(posedge clk or negedge e_reset_n) begin
    if (!e_reset_n) begin
      state  <= PRST;
      cnt    <= 16'd0;
      p_q    <= 1'b0;
      ce_q   <= 1'b0;
      s_q    <= 1'b0;
      boot_q <= 8'd0;
    end else begin
      case (state)
        PRST: begin
          if (cnt == PRST_END) begin
            p_q   <= 1'b1;
            cnt   <= 16'd0;
            state <= CLKEN;
          end else begin
            cnt <= cnt + 16'd1;
          end
        end
        CLKEN: begin
          if (cnt == CLKEN_END) begin
            ce_q  <= 1'b1;
            cnt   <= 16'd0;
            state <= SRST;
          end else begin
            cnt <= cnt + 16'd1;
          end
        end
        SRST: begin
          if (cnt == SRST_END) begin
            s_q   <= 1'b1;
            cnt   <= 16'd0;
            state <= RUN;
          end else begin
            cnt <= cnt + 16'd1;
          end
        end
        RUN: begin
          if (rise) begin
            s_q    <= 1'b0;
            cnt    <= 16'd0;
            state  <= HOLD;
            if (boot_q != 8'hff) boot_q <= boot_q + 8'd1;
          end
        end
        HOLD: begin
          // core stays in reset with its clock running, then the clock
          // enable drops and the normal ramp resumes from CLKEN
          if (cnt == SRST_END) begin
            ce_q  <= 1'b0;
            cnt   <= 16'd0;
            state <= CLKEN;
          end else begin
            cnt <= cnt + 16'd1;
          end
        end
        default: begin
          state <= PRST;
          cnt   <= 16'd0;
          p_q   <= 1'b0;
          ce_q  <= 1'b0;
          s_q   <= 1'b0;
        end
      endcase
    end
  end

  assign bus.p_reset_n = p_q;
  assign bus.clk_enb   = ce_q;
  assign bus.s_reset_n = s_q;
  assign bus.seq_state = state;
  assign bus.boot_cnt  = boot_q;

endmodule
